operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 130 +++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: 4x16 register file with carry, one-entry decode slot,
// per-register pending scoreboard with write-back forwarding, and a registered issue slot.
module operand_fetch (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] INSTR_IN,
  input  logic [15:0] PC_IN,
  input  logic [15:0] MEM_DATA,
  output logic [15:0] INSTR,
  input  logic [1:0]  RnSelect,
  input  logic [2:0]  RmSelect,
  input  logic [1:0]  RxSelect,
  input  logic        DEST_EN,
  input  logic [1:0]  DEST_SEL,
  output logic [15:0] Rn,
  output logic [15:0] Rm,
  output logic [15:0] Rx,
  output logic        CARRY,
  input  logic        WB_EN,
  input  logic [1:0]  WB_ADDR,
  input  logic [15:0] WB_DATA,
  input  logic        WB_CARRY_EN,
  input  logic        WB_CARRY,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] EX_INSTR,
  output logic [15:0] EX_RN,
  output logic [15:0] EX_RM,
  output logic [15:0] EX_RX
);

  logic [15:0] regs [4];
  logic        carry_q;
  logic [3:0]  pending, pending_next;
  logic        slot_valid;
  logic [15:0] slot_instr, slot_pc;
  logic        out_valid;

  logic [15:0] rd [4];
  logic [3:0]  busy;
  logic        hazard, issue, accept;

  // A same-cycle write-back both forwards its data and releases the pending bit.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      rd[i]   = (WB_EN && WB_ADDR == 2'(i)) ? WB_DATA : regs[i];
      busy[i] = pending[i] && !(WB_EN && WB_ADDR == 2'(i));
    end
  end

  always_comb begin
    Rn = rd[RnSelect];
    Rx = rd[RxSelect];
    Rm = '0;
    case (RmSelect)
      3'd4:       Rm = MEM_DATA;
      3'd5:       Rm = {8'h00, slot_instr[7:0]};
      3'd6, 3'd7: Rm = slot_pc;
      default:    Rm = rd[RmSelect[1:0]];
    endcase
  end

  assign CARRY  = WB_CARRY_EN ? WB_CARRY : carry_q;
  assign INSTR  = slot_instr;
  assign hazard = slot_valid &&
                  (busy[RnSelect] || (!RmSelect[2] && busy[RmSelect[1:0]]) || busy[RxSelect]);
  assign issue    = slot_valid && !hazard && (!out_valid || OUT_READY);
  assign IN_READY = !RESET && (!slot_valid || issue);
  assign accept   = IN_VALID && IN_READY;
  assign OUT_VALID = out_valid;

  // Clear is applied before set so a same-cycle issue to the same register keeps it pending.
  always_comb begin
    pending_next = pending;
    if (WB_EN)
      pending_next[WB_ADDR] = 1'b0;
    if (issue && DEST_EN)
      pending_next[DEST_SEL] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < 4; i++)
        regs[i] <= '0;
      carry_q <= 1'b0;
      pending <= '0;
    end else begin
      if (WB_EN)
        regs[WB_ADDR] <= WB_DATA;
      if (WB_CARRY_EN)
        carry_q <= WB_CARRY;
      pending <= pending_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      slot_valid <= 1'b0;
      slot_instr <= '0;
      slot_pc    <= '0;
    end else if (accept) begin
      slot_valid <= 1'b1;
      slot_instr <= INSTR_IN;
      slot_pc    <= PC_IN;
    end else if (issue) begin
      slot_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      EX_INSTR  <= '0;
      EX_RN     <= '0;
      EX_RM     <= '0;
      EX_RX     <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      EX_INSTR  <= slot_instr;
      EX_RN     <= Rn;
      EX_RM     <= Rm;
      EX_RX     <= Rx;
    end else if (OUT_READY) begin
      out_valid <= 1'b0;
    end
  end

endmodule
